// File: rtl/mem_bus_if.sv
// Bridge from a pipeline memory port to a multi-cycle ack-handshaked bus; stalls the stage until the slave acks.
// Optional BUS_TIMEOUT_EN aborts a BUSY access after TIMEOUT_CYCLES and pulses err_o.
module mem_bus_if #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i,
`ifdef BUS_TIMEOUT_EN
  output logic              err_o,
`endif
  output logic [1:0]        dbg_state
);

  if (DATA_W % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_bus_if: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rd_buf;
  logic              start;
  logic              done;
  logic              timeout;

  assign dbg_state = state;
  assign start     = (state == IDLE) && cpu_ce_i && !flush_i;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // The TIMEOUT_CYCLES-th BUSY cycle without ack is the abort cycle.
  assign timeout = (state == BUSY) && !bus_ack_i && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_o   <= 1'b0;
    end else begin
      err_o <= timeout && !flush_i;
      if (start)
        tmo_cnt <= '0;
      else if (state == BUSY && !bus_ack_i)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Flush wins over both ack and timeout.
  assign done = (state == BUSY) && !flush_i && (bus_ack_i || timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (state)
      IDLE: begin
        stallreq_o = cpu_ce_i && !flush_i;
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (done) begin
          if (bus_ack_i && !bus_we_o) cpu_data_o = bus_data_i;
          state_nxt = stall_i ? WAIT_STALL : IDLE;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf;
        if (flush_i || !stall_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_cyc_o  <= 1'b0;
      bus_stb_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_sel_o  <= '0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
      rd_buf     <= '0;
    end else if (start) begin
      bus_cyc_o  <= 1'b1;
      bus_stb_o  <= 1'b1;
      bus_we_o   <= cpu_we_i;
      bus_sel_o  <= cpu_sel_i;
      bus_addr_o <= cpu_addr_i;
      bus_data_o <= cpu_data_i;
    end else if (state == BUSY && (flush_i || done)) begin
      bus_cyc_o  <= 1'b0;
      bus_stb_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_sel_o  <= '0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
      if (done) rd_buf <= (bus_ack_i && !bus_we_o) ? bus_data_i : '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: vector table of bus accesses plus hand-written flush, reset and idle-ack sequences.
module tb_mem_bus_if;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i, bus_sel_o;
  logic        stallreq_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_data_o, bus_data_i;
  logic [1:0]  dbg_state;
`ifdef BUS_TIMEOUT_EN
  logic        err_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    int          stall_after;
  } vec_t;

  vec_t vecs[7];

  mem_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
    .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
`ifdef BUS_TIMEOUT_EN
    .err_o(err_o),
`endif
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    stall_i = 0; flush_i = 0; cpu_ce_i = 0; cpu_we_i = 0;
    cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
    bus_data_i = '0; bus_ack_i = 0;
  endtask

  task automatic check_bus_clear(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, "_cyc"}, 32'(bus_cyc_o), 32'd0);
    chk({tag, "_stb"}, 32'(bus_stb_o), 32'd0);
    chk({tag, "_we"}, 32'(bus_we_o), 32'd0);
    chk({tag, "_sel"}, 32'(bus_sel_o), 32'd0);
    chk({tag, "_addr"}, bus_addr_o, 32'd0);
    chk({tag, "_wdata"}, bus_data_o, 32'd0);
  endtask

  // One full access: request cycle, waits+1 BUSY cycles, stall_after WAIT_STALL cycles, then IDLE.
  task automatic run_vec(input vec_t v);
    logic [31:0] exp_out;
    logic [31:0] got;
    exp_out = v.we ? 32'd0 : v.rdata;
    cpu_ce_i = 1; cpu_we_i = v.we; cpu_addr_i = v.addr;
    cpu_sel_i = v.sel; cpu_data_i = v.wdata;
    stall_i = 0; flush_i = 0; bus_ack_i = 0;
    exp_q.push_back(exp_out);
    @(negedge clk);
    chk("req_stallreq", 32'(stallreq_o), 32'd1);
    chk("req_cyc", 32'(bus_cyc_o), 32'd0);
    chk("req_rdata", cpu_data_o, 32'd0);
    next_cycle();
    for (int w = 0; w <= v.waits; w++) begin
      bus_ack_i  = (w == v.waits);
      bus_data_i = v.rdata;
      stall_i    = bus_ack_i && (v.stall_after > 0);
      @(negedge clk);
      chk("busy_state", 32'(dbg_state), 32'(ST_BUSY));
      chk("busy_cyc", 32'(bus_cyc_o), 32'd1);
      chk("busy_stb", 32'(bus_stb_o), 32'd1);
      chk("busy_we", 32'(bus_we_o), 32'(v.we));
      chk("busy_sel", 32'(bus_sel_o), 32'(v.sel));
      chk("busy_addr", bus_addr_o, v.addr);
      chk("busy_wdata", bus_data_o, v.wdata);
      chk("busy_stallreq", 32'(stallreq_o), 32'(!bus_ack_i));
      if (bus_ack_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_rdata: actual=%h required=queued_value", cpu_data_o);
        end else begin
          got = exp_q.pop_front();
          chk("ack_rdata", cpu_data_o, got);
        end
      end else begin
        chk("busy_rdata", cpu_data_o, 32'd0);
      end
      next_cycle();
    end
    bus_ack_i = 0; cpu_ce_i = 0;
    bus_data_i = $urandom;
    for (int k = 0; k < v.stall_after; k++) begin
      stall_i = (k < v.stall_after - 1);
      @(negedge clk);
      chk("wait_state", 32'(dbg_state), 32'(ST_WAIT));
      chk("wait_stallreq", 32'(stallreq_o), 32'd0);
      chk("wait_rdata", cpu_data_o, exp_out);
      chk("wait_cyc", 32'(bus_cyc_o), 32'd0);
      next_cycle();
    end
    stall_i = 0;
    @(negedge clk);
    check_bus_clear("post");
    chk("post_rdata", cpu_data_o, 32'd0);
  endtask

  initial begin
    vecs[0] = '{we: 1'b0, addr: 32'h100, sel: 4'hF, wdata: 32'h0,        waits: 0, rdata: 32'hDEADBEEF, stall_after: 0};
    vecs[1] = '{we: 1'b1, addr: 32'h200, sel: 4'h3, wdata: 32'h12345678, waits: 3, rdata: 32'hCAFEF00D, stall_after: 0};
    vecs[2] = '{we: 1'b0, addr: 32'h300, sel: 4'hF, wdata: 32'h0,        waits: 1, rdata: 32'hA5A5A5A5, stall_after: 2};
    vecs[3] = '{we: 1'b1, addr: 32'h304, sel: 4'hC, wdata: 32'h0BADC0DE, waits: 0, rdata: 32'h77777777, stall_after: 1};
    for (int i = 4; i < 7; i++) begin
      vecs[i].we          = 1'($urandom_range(0, 1));
      vecs[i].addr        = $urandom & 32'hFFFF_FFFC;
      vecs[i].sel         = 4'($urandom_range(1, 15));
      vecs[i].wdata       = $urandom;
      vecs[i].waits       = $urandom_range(0, 4);
      vecs[i].rdata       = $urandom;
      vecs[i].stall_after = $urandom_range(0, 2);
    end

    // reset
    drive_idle();
    rst = 1;
    #12;
    check_bus_clear("reset");
    chk("reset_stallreq", 32'(stallreq_o), 32'd0);
    chk("reset_rdata", cpu_data_o, 32'd0);
`ifdef BUS_TIMEOUT_EN
    chk("reset_err", 32'(err_o), 32'd0);
`endif
    @(negedge clk);
    rst = 0;
    next_cycle();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      next_cycle();
    end

    // ack outside BUSY is ignored
    bus_ack_i = 1; bus_data_i = 32'h33334444;
    @(negedge clk);
    chk("idle_ack_rdata", cpu_data_o, 32'd0);
    chk("idle_ack_stallreq", 32'(stallreq_o), 32'd0);
    next_cycle();
    bus_ack_i = 0;
    @(negedge clk);
    check_bus_clear("idle_ack");
    next_cycle();

    // flush in IDLE blocks the request
    cpu_ce_i = 1; flush_i = 1; cpu_addr_i = 32'h400;
    @(negedge clk);
    chk("idle_flush_stallreq", 32'(stallreq_o), 32'd0);
    next_cycle();
    cpu_ce_i = 0; flush_i = 0;
    @(negedge clk);
    check_bus_clear("idle_flush");
    next_cycle();

    // flush together with ack in the 2nd BUSY cycle
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h500; cpu_sel_i = 4'hF;
    next_cycle();
    @(negedge clk);
    chk("fl_busy1_stallreq", 32'(stallreq_o), 32'd1);
    next_cycle();
    bus_ack_i = 1; flush_i = 1; bus_data_i = 32'h11111111;
    @(negedge clk);
    chk("fl_busy2_stallreq", 32'(stallreq_o), 32'd0);
    chk("fl_busy2_rdata", cpu_data_o, 32'd0);
    next_cycle();
    bus_ack_i = 0; flush_i = 0; cpu_ce_i = 0;
    @(negedge clk);
    check_bus_clear("fl_after");
    chk("fl_after_rdata", cpu_data_o, 32'd0);
    next_cycle();

    // flush leaves WAIT_STALL even while stall_i stays high
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h600;
    next_cycle();
    bus_ack_i = 1; stall_i = 1; bus_data_i = 32'h5A5A0F0F;
    next_cycle();
    bus_ack_i = 0; cpu_ce_i = 0; flush_i = 1; bus_data_i = 32'h0;
    @(negedge clk);
    chk("ws_flush_state", 32'(dbg_state), 32'(ST_WAIT));
    chk("ws_flush_rdata", cpu_data_o, 32'h5A5A0F0F);
    next_cycle();
    flush_i = 0;
    @(negedge clk);
    chk("ws_flush_exit", 32'(dbg_state), 32'(ST_IDLE));
    stall_i = 0;
    next_cycle();

    // asynchronous reset in the middle of a BUSY cycle
    cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h700; cpu_data_i = 32'h99;
    next_cycle();
    #2;
    chk("arst_pre_cyc", 32'(bus_cyc_o), 32'd1);
    rst = 1;
    #1;
    chk("arst_cyc", 32'(bus_cyc_o), 32'd0);
    chk("arst_stb", 32'(bus_stb_o), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    cpu_ce_i = 0;
    @(negedge clk);
    rst = 0;
    next_cycle();
    @(negedge clk);
    check_bus_clear("arst_after");

`ifdef BUS_TIMEOUT_EN
    // no ack: abort on the 4th BUSY cycle, err_o pulses once
    next_cycle();
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h800; bus_data_i = 32'hFFFFFFFF;
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("tmo_stallreq", 32'(stallreq_o), 32'(c < 4));
      chk("tmo_rdata", cpu_data_o, 32'd0);
      chk("tmo_err_low", 32'(err_o), 32'd0);
      next_cycle();
    end
    cpu_ce_i = 0;
    @(negedge clk);
    chk("tmo_err_pulse", 32'(err_o), 32'd1);
    check_bus_clear("tmo_after");
    next_cycle();
    @(negedge clk);
    chk("tmo_err_clear", 32'(err_o), 32'd0);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
